// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM memory responder.
// Defines the responder state encoding, the MMIO register offsets and the default MMIO window tag.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] OFF_CYCLE    = 4'h0;
    localparam logic [3:0] OFF_RESULT   = 4'h4;
    localparam logic [3:0] OFF_HALT     = 4'h8;
    localparam logic [3:0] DEF_MMIO_TAG = 4'hF;

endpackage

// File: rtl/mem_ram_2r1w.sv
// Word array with two combinational read ports (fetch, data) and one synchronous write port.
// Reads have zero latency; a write lands at the clock edge, so a same-cycle read returns the old word.
module mem_ram_2r1w #(
    parameter int MEM_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [31:0]                  wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr_f,
    output logic [31:0]                  rdata_f,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr_d,
    output logic [31:0]                  rdata_d
);

    logic [31:0] mem [MEM_WORDS];

    // Contents are deliberately left unreset so a reload can patch a resident program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_f = mem[raddr_f];
    assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the pipelined ARM core: program loader, shared instruction/data array, MMIO window.
// Zero-latency reads; the load port is valid/ready with ready held high only while the core is kept in reset.
module arm_mem_responder
    import arm_mem_pkg::*;
#(
    parameter int         MEM_WORDS = 256,
    parameter logic [3:0] MMIO_TAG  = DEF_MMIO_TAG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic [31:0] InstrF,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    input  logic        LoadStart,
    input  logic        LoadValid,
    input  logic [31:0] LoadData,
    input  logic        LoadLast,
    output logic        LoadReady,
    output logic        CoreReset,
    output logic        Halted,
    output logic [31:0] ResultOut,
    output logic [31:0] CycleCount,
    output logic        LoadOverflow
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  ptr;
    logic           load_hs;
    logic           restart;
    logic           is_mmio;
    logic [3:0]     mmio_off;
    logic           run_store;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;

    assign LoadReady = (state == LOAD);
    assign CoreReset = (state != RUN);
    assign Halted    = (state == HALT);

    assign load_hs   = LoadValid && LoadReady;
    assign restart   = LoadStart && (state != LOAD);
    assign is_mmio   = (ALUOutM[31:28] == MMIO_TAG);
    assign mmio_off  = ALUOutM[3:0];
    // A restart request in the same cycle drops the core's store entirely.
    assign run_store = (state == RUN) && MemWriteM && !LoadStart;

    assign mem_we    = !reset && (load_hs || (run_store && !is_mmio));
    assign mem_waddr = (state == LOAD) ? ptr : ALUOutM[AW+1:2];
    assign mem_wdata = (state == LOAD) ? LoadData : WriteDataM;

    mem_ram_2r1w #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_f (PCF[AW+1:2]),
        .rdata_f (InstrF),
        .raddr_d (ALUOutM[AW+1:2]),
        .rdata_d (mem_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (load_hs && LoadLast) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (LoadStart) begin
                    state_nxt = LOAD;
                end else if (run_store && is_mmio && (mmio_off == OFF_HALT)) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (LoadStart) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            ptr          <= '0;
            LoadOverflow <= 1'b0;
            CycleCount   <= '0;
            ResultOut    <= '0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                ptr          <= '0;
                LoadOverflow <= 1'b0;
                CycleCount   <= '0;
            end else begin
                if (load_hs) begin
                    ptr <= ptr + AW'(1);
                    if (&ptr) begin
                        LoadOverflow <= 1'b1;
                    end
                end
                if (state == RUN) begin
                    CycleCount <= CycleCount + 32'd1;
                end
                if (run_store && is_mmio && (mmio_off == OFF_RESULT)) begin
                    ResultOut <= WriteDataM;
                end
            end
        end
    end

    // Halt and unmapped offsets read as zero.
    always_comb begin
        ReadDataM = mem_rdata;
        if (is_mmio) begin
            case (mmio_off)
                OFF_CYCLE:  ReadDataM = CycleCount;
                OFF_RESULT: ReadDataM = ResultOut;
                default:    ReadDataM = '0;
            endcase
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{PCF[31:AW+2], PCF[1:0], ALUOutM[27:AW+2], ALUOutM[1:0]};

endmodule

// File: tb/tb_arm_mem_responder.sv
`timescale 1ns/1ps
module tb_arm_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, MemWriteM, LoadStart, LoadValid, LoadLast;
    logic [31:0] PCF, ALUOutM, WriteDataM, LoadData;

    logic [31:0] instr_a, rd_a, res_a, cyc_a;
    logic        lrdy_a, crst_a, halt_a, ovf_a;
    logic [31:0] instr_b, rd_b, res_b, cyc_b;
    logic        lrdy_b, crst_b, halt_b, ovf_b;

    int total = 0;
    int bad   = 0;

    arm_mem_responder #(.MEM_WORDS(256), .MMIO_TAG(4'hF)) dut_a (
        .clk(clk), .reset(reset), .PCF(PCF), .InstrF(instr_a),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(rd_a),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast),
        .LoadReady(lrdy_a), .CoreReset(crst_a), .Halted(halt_a), .ResultOut(res_a),
        .CycleCount(cyc_a), .LoadOverflow(ovf_a)
    );

    arm_mem_responder #(.MEM_WORDS(4), .MMIO_TAG(4'hF)) dut_b (
        .clk(clk), .reset(reset), .PCF(PCF), .InstrF(instr_b),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(rd_b),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast),
        .LoadReady(lrdy_b), .CoreReset(crst_b), .Halted(halt_b), .ResultOut(res_b),
        .CycleCount(cyc_b), .LoadOverflow(ovf_b)
    );

    // Abstract model: mode, per-depth word arrays with known flags, pointers, counters.
    typedef enum int {M_LOAD, M_RUN, M_HALT} mode_e;
    mode_e       ms;
    logic [31:0] ma [256];
    bit          ka [256];
    logic [31:0] mb [4];
    bit          kb [4];
    int          pa, pb;
    bit          oa, ob;
    logic [31:0] mcyc, mres;
    bit          model_ok = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_word(input bit side_b, input logic [31:0] addr, output logic [31:0] v);
        int i;
        if (side_b) begin
            i = int'((addr >> 2) % 4);
            v = mb[i];
            return kb[i];
        end
        i = int'((addr >> 2) % 256);
        v = ma[i];
        return ka[i];
    endfunction

    function automatic bit model_read(input bit side_b, input logic [31:0] addr, output logic [31:0] v);
        if (addr[31:28] == 4'hF) begin
            v = (addr[3:0] == 4'h0) ? mcyc : (addr[3:0] == 4'h4) ? mres : 32'h0;
            return 1'b1;
        end
        return model_word(side_b, addr, v);
    endfunction

    task automatic model_restart();
        ms = M_LOAD; pa = 0; pb = 0; oa = 0; ob = 0; mcyc = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            ms = M_LOAD; pa = 0; pb = 0; oa = 0; ob = 0; mcyc = 0; mres = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            case (ms)
                M_LOAD: if (LoadValid) begin
                    ma[pa] = LoadData; ka[pa] = 1'b1;
                    mb[pb] = LoadData; kb[pb] = 1'b1;
                    if (pa == 255) oa = 1'b1;
                    if (pb == 3) ob = 1'b1;
                    pa = (pa + 1) % 256;
                    pb = (pb + 1) % 4;
                    if (LoadLast) ms = M_RUN;
                end
                M_RUN: if (LoadStart) begin
                    model_restart();
                end else begin
                    mcyc = mcyc + 32'd1;
                    if (MemWriteM) begin
                        if (ALUOutM[31:28] == 4'hF) begin
                            if (ALUOutM[3:0] == 4'h4) mres = WriteDataM;
                            else if (ALUOutM[3:0] == 4'h8) ms = M_HALT;
                        end else begin
                            ma[int'((ALUOutM >> 2) % 256)] = WriteDataM;
                            ka[int'((ALUOutM >> 2) % 256)] = 1'b1;
                            mb[int'((ALUOutM >> 2) % 4)] = WriteDataM;
                            kb[int'((ALUOutM >> 2) % 4)] = 1'b1;
                        end
                    end
                end
                default: if (LoadStart) model_restart();
            endcase
        end
    end

    always @(negedge clk) begin
        logic [31:0] v;
        if (model_ok) begin
            cmp("LoadReady_a", {31'b0, lrdy_a}, {31'b0, ms == M_LOAD});
            cmp("CoreReset_a", {31'b0, crst_a}, {31'b0, ms != M_RUN});
            cmp("Halted_a", {31'b0, halt_a}, {31'b0, ms == M_HALT});
            cmp("LoadOverflow_a", {31'b0, ovf_a}, {31'b0, oa});
            cmp("ResultOut_a", res_a, mres);
            cmp("CycleCount_a", cyc_a, mcyc);
            cmp("LoadReady_b", {31'b0, lrdy_b}, {31'b0, ms == M_LOAD});
            cmp("Halted_b", {31'b0, halt_b}, {31'b0, ms == M_HALT});
            cmp("CoreReset_b", {31'b0, crst_b}, {31'b0, ms != M_RUN});
            cmp("LoadOverflow_b", {31'b0, ovf_b}, {31'b0, ob});
            cmp("ResultOut_b", res_b, mres);
            cmp("CycleCount_b", cyc_b, mcyc);
            if (model_word(1'b0, PCF, v)) cmp("InstrF_a", instr_a, v);
            if (model_word(1'b1, PCF, v)) cmp("InstrF_b", instr_b, v);
            if (model_read(1'b0, ALUOutM, v)) cmp("ReadDataM_a", rd_a, v);
            if (model_read(1'b1, ALUOutM, v)) cmp("ReadDataM_b", rd_b, v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w, input logic last);
        LoadValid = 1'b1; LoadData = w; LoadLast = last;
        tick();
        LoadValid = 1'b0; LoadLast = 1'b0;
    endtask

    logic [31:0] prog [9];

    initial begin
        prog[0] = 32'hE3A00005; prog[1] = 32'hE3A0100A; prog[2] = 32'hE0802001;
        prog[3] = 32'hA0000001; prog[4] = 32'hA0000002; prog[5] = 32'hA0000003;
        prog[6] = 32'hA0000004; prog[7] = 32'hA0000005; prog[8] = 32'hB0000001;

        reset = 1'b1; MemWriteM = 1'b0; LoadStart = 1'b0; LoadValid = 1'b0; LoadLast = 1'b0;
        PCF = 32'h0; ALUOutM = 32'h0; WriteDataM = 32'h0; LoadData = 32'h0;
        tick(); tick();
        cmp("rst_LoadReady", {31'b0, lrdy_a}, 32'd1);
        cmp("rst_CoreReset", {31'b0, crst_a}, 32'd1);
        cmp("rst_Halted", {31'b0, halt_a}, 32'd0);
        cmp("rst_CycleCount", cyc_a, 32'd0);
        cmp("rst_ResultOut", res_a, 32'd0);
        cmp("rst_LoadOverflow", {31'b0, ovf_a}, 32'd0);
        reset = 1'b0;

        // Three-word program; first RUN cycle follows the LoadLast handshake.
        for (int i = 0; i < 3; i++) load_word(prog[i], i == 2);
        PCF = 32'h4; ALUOutM = 32'hF0000000;
        #1;
        cmp("run0_LoadReady", {31'b0, lrdy_a}, 32'd0);
        cmp("run0_CoreReset", {31'b0, crst_a}, 32'd0);
        cmp("run0_InstrF", instr_a, 32'hE3A0100A);
        cmp("run0_Cycle", rd_a, 32'd0);

        repeat (10) tick();
        #1;
        cmp("cycle_read10", rd_a, 32'd10);
        MemWriteM = 1'b1; WriteDataM = 32'h123;
        tick();
        MemWriteM = 1'b0;
        #1;
        cmp("cycle_store_ignored", rd_a, 32'd11);

        // Data store, then same-cycle old-value read and following-cycle new value.
        ALUOutM = 32'h40; WriteDataM = 32'h11111111; MemWriteM = 1'b1;
        tick();
        WriteDataM = 32'hDEADBEEF;
        #1;
        cmp("store_cycle_old", rd_a, 32'h11111111);
        tick();
        MemWriteM = 1'b0; PCF = 32'h40;
        #1;
        cmp("load_after_store", rd_a, 32'hDEADBEEF);
        cmp("fetch_after_store", instr_a, 32'hDEADBEEF);

        ALUOutM = 32'hF0000004; WriteDataM = 32'h2A; MemWriteM = 1'b1;
        tick();
        ALUOutM = 32'hF0000008; WriteDataM = 32'h5;
        tick();
        MemWriteM = 1'b0;
        #1;
        cmp("halt_Halted", {31'b0, halt_a}, 32'd1);
        cmp("halt_CoreReset", {31'b0, crst_a}, 32'd1);
        cmp("halt_Result", res_a, 32'h2A);
        cmp("halt_reg_reads0", rd_a, 32'd0);
        ALUOutM = 32'hF000000C;
        repeat (3) tick();
        cmp("halt_cycle_frozen", cyc_a, 32'd15);
        cmp("unmapped_reads0", rd_a, 32'd0);

        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        #1;
        cmp("restart_LoadReady", {31'b0, lrdy_a}, 32'd1);
        cmp("restart_Halted", {31'b0, halt_a}, 32'd0);
        cmp("restart_Cycle", cyc_a, 32'd0);
        cmp("restart_Result", res_a, 32'h2A);

        // Five words overflow the 4-word instance.
        for (int i = 3; i < 8; i++) load_word(prog[i], i == 7);
        PCF = 32'h10;
        #1;
        cmp("ovf_b", {31'b0, ovf_b}, 32'd1);
        cmp("ovf_a", {31'b0, ovf_a}, 32'd0);
        cmp("alias_b_word0", instr_b, prog[7]);
        cmp("word4_a", instr_a, prog[7]);

        LoadStart = 1'b1; ALUOutM = 32'hF0000008; MemWriteM = 1'b1;
        tick();
        LoadStart = 1'b0; MemWriteM = 1'b0;
        #1;
        cmp("ls_halt_LoadReady", {31'b0, lrdy_a}, 32'd1);
        cmp("ls_halt_Halted", {31'b0, halt_a}, 32'd0);
        cmp("ls_halt_Cycle", cyc_a, 32'd0);
        cmp("ls_halt_Result", res_a, 32'h2A);

        load_word(prog[8], 1'b1);
        LoadStart = 1'b1; ALUOutM = 32'h8; WriteDataM = 32'h77; MemWriteM = 1'b1;
        tick();
        LoadStart = 1'b0; MemWriteM = 1'b0; PCF = 32'h8;
        #1;
        cmp("ls_store_dropped_a", instr_a, prog[5]);
        cmp("ls_store_dropped_b", instr_b, prog[5]);

        // Reset mid-load rewinds the pointer but keeps written words.
        load_word(32'hC0000006, 1'b0);
        load_word(32'hC0000007, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_word(32'hC0000008, 1'b1);
        PCF = 32'h0;
        #1;
        cmp("midreset_word0", instr_a, 32'hC0000008);
        PCF = 32'h4;
        #1;
        cmp("midreset_word1", instr_a, 32'hC0000007);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
